// File: rtl/mult_seq_ctrl.sv
// Sequencer for the repeated-addition multiplier datapath (A reg, B down-counter, P accumulator).
// Define MULT_CTRL_TIMEOUT_EN to enable the MAX_ITER iteration limit and the ERR state.
module mult_seq_ctrl #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              eqz,
  output logic              ld_a,
  output logic              ld_b,
  output logic              clr_p,
  output logic              ld_p,
  output logic              dec_b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [2:0]        state_o
);

`ifdef MULT_CTRL_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [ITER_W-1:0] IterMax = '1;
  localparam logic [ITER_W-1:0] IterLim = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CHECK  = 3'd3,
    S_ACC    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;

    // The counter follows the current state only, so an abort taken in ACC still counts that cycle.
    case (state_q)
      S_LOAD_A: iter_d = '0;
      S_ACC:    if (iter_q != IterMax) iter_d = iter_q + ITER_W'(1);
      default:  ;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start && !abort) state_d = S_LOAD_A;
        S_LOAD_A: state_d = S_LOAD_B;
        S_LOAD_B: state_d = S_CHECK;
        S_CHECK: begin
          if (eqz)                                state_d = S_DONE;
          else if (TimeoutEn && iter_q == IterLim) state_d = S_ERR;
          else                                    state_d = S_ACC;
        end
        S_ACC:    state_d = S_CHECK;
        S_DONE:   state_d = start ? S_LOAD_A : S_IDLE;
        S_ERR:    if (start) state_d = S_LOAD_A;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  assign ld_a     = (state_q == S_LOAD_A);
  assign ld_b     = (state_q == S_LOAD_B);
  assign clr_p    = (state_q == S_LOAD_B);
  assign ld_p     = (state_q == S_ACC);
  assign dec_b    = (state_q == S_ACC);
  assign busy     = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                    (state_q == S_CHECK)  || (state_q == S_ACC);
  assign done     = (state_q == S_DONE);
  assign err      = TimeoutEn && (state_q == S_ERR);
  assign iter_cnt = iter_q;
  assign state_o  = state_q;

endmodule
